// File: rtl/axi_pkg.sv
// Minimal AXI definitions shared by the DMA backend.
// Only the response encoding is needed by the response tracker.
package axi_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through, common_cells compatible ports.
// A push while full or a pop while empty is ignored.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam logic [ADDR_DEPTH:0]   FullCnt = (ADDR_DEPTH + 1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(DEPTH - 1);

    logic [ADDR_DEPTH-1:0] rptr_q, rptr_d;
    logic [ADDR_DEPTH-1:0] wptr_q, wptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic                  do_push;
    logic                  do_pop;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        mem_we = 1'b0;
        data_o = mem_q[rptr_q];
        if (do_push) begin
            mem_we = 1'b1;
            wptr_d = ptr_inc(wptr_q);
            cnt_d  = cnt_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = ptr_inc(rptr_q);
            cnt_d  = do_push ? cnt_q : cnt_q - 1'b1;
        end
        // Fall-through on an empty FIFO bypasses storage entirely.
        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                rptr_d = rptr_q;
                wptr_d = wptr_q;
                cnt_d  = cnt_q;
                mem_we = 1'b0;
            end
        end
        if (flush_i) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            if (mem_we) begin
                mem_q[wptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/axi_dma_resp_tracker.sv
// Tracks issued AW bursts and coalesces in-order B responses into one
// completion per 1D transfer, with sticky error and burst count.
module axi_dma_resp_tracker
    import axi_pkg::*;
#(
    parameter  int unsigned NumOutstanding = 16,
    localparam int unsigned CntWidth       = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                aw_issue_valid_i,
    input  logic                aw_issue_last_i,
    output logic                aw_issue_ready_o,
    input  logic                b_valid_i,
    input  resp_t               b_resp_i,
    output logic                b_ready_o,
    output logic                done_valid_o,
    input  logic                done_ready_i,
    output logic                done_error_o,
    output logic [CntWidth-1:0] done_num_bursts_o,
    output logic                idle_o
);

    localparam int unsigned AddrW = $clog2(NumOutstanding);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDonePend
    } ctrl_e;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_last;
    logic [AddrW-1:0]    fifo_usage_unused;
    logic                aw_push;
    logic                b_hs;
    logic                b_err;
    logic [CntWidth-1:0] cnt_inc;
    ctrl_e               ctrl_state;

    logic                err_q, err_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                done_valid_q, done_valid_d;
    logic                done_err_q, done_err_d;
    logic [CntWidth-1:0] done_num_q, done_num_d;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (1),
        .DEPTH        (NumOutstanding)
    ) i_last_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage_unused),
        .data_i     (aw_issue_last_i),
        .push_i     (aw_push),
        .data_o     (fifo_last),
        .pop_i      (b_hs)
    );

    assign aw_issue_ready_o = !fifo_full;
    assign aw_push          = aw_issue_valid_i && aw_issue_ready_o;
    // B is only taken when the output slot is free or draining this cycle.
    assign b_ready_o        = !fifo_empty && (!done_valid_q || done_ready_i);
    assign b_hs             = b_valid_i && b_ready_o;
    assign b_err            = b_resp_i[1];
    assign cnt_inc          = sat_inc(cnt_q);

    always_comb begin
        err_d        = err_q;
        cnt_d        = cnt_q;
        done_valid_d = done_valid_q;
        done_err_d   = done_err_q;
        done_num_d   = done_num_q;
        if (done_valid_q && done_ready_i) begin
            done_valid_d = 1'b0;
        end
        if (b_hs) begin
            if (fifo_last) begin
                done_valid_d = 1'b1;
                done_err_d   = err_q | b_err;
                done_num_d   = cnt_inc;
                err_d        = 1'b0;
                cnt_d        = '0;
            end else begin
                err_d = err_q | b_err;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q        <= 1'b0;
            cnt_q        <= '0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            done_num_q   <= '0;
        end else begin
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            done_valid_q <= done_valid_d;
            done_err_q   <= done_err_d;
            done_num_q   <= done_num_d;
        end
    end

    always_comb begin
        ctrl_state = StIdle;
        if (done_valid_q) begin
            ctrl_state = StDonePend;
        end else if (!fifo_empty || (cnt_q != '0)) begin
            ctrl_state = StAccum;
        end
    end

    assign idle_o            = (ctrl_state == StIdle);
    assign done_valid_o      = done_valid_q;
    assign done_error_o      = done_err_q;
    assign done_num_bursts_o = done_num_q;

`ifndef SYNTHESIS
    b_hs_needs_entry : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (b_valid_i && b_ready_o) |-> !fifo_empty
    ) else $fatal(1, "B handshake with empty tracker FIFO");
`endif

endmodule

// File: tb/tb_axi_dma_resp_tracker.sv
// Scoreboard bench for axi_dma_resp_tracker: directed transfers push
// expected completions, a monitor pops them on each done handshake.
module tb_axi_dma_resp_tracker;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        aw_issue_valid_i = 1'b0;
    logic        aw_issue_last_i = 1'b0;
    logic        aw_issue_ready_o;
    logic        b_valid_i = 1'b0;
    logic [1:0]  b_resp_i = 2'b00;
    logic        b_ready_o;
    logic        done_valid_o;
    logic        done_ready_i = 1'b1;
    logic        done_error_o;
    logic [15:0] done_num_bursts_o;
    logic        idle_o;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];

    axi_dma_resp_tracker #(
        .NumOutstanding (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .aw_issue_valid_i  (aw_issue_valid_i),
        .aw_issue_last_i   (aw_issue_last_i),
        .aw_issue_ready_o  (aw_issue_ready_o),
        .b_valid_i         (b_valid_i),
        .b_resp_i          (b_resp_i),
        .b_ready_o         (b_ready_o),
        .done_valid_o      (done_valid_o),
        .done_ready_i      (done_ready_i),
        .done_error_o      (done_error_o),
        .done_num_bursts_o (done_num_bursts_o),
        .idle_o            (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic last);
        aw_issue_valid_i = 1'b1;
        aw_issue_last_i  = last;
        step();
        aw_issue_valid_i = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] r);
        int n;
        n = 0;
        b_valid_i = 1'b1;
        b_resp_i  = r;
        @(negedge clk_i);
        while (!b_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("b_accept", int'(b_ready_o), 1);
        step();
        b_valid_i = 1'b0;
    endtask

    task automatic exp_done(input logic err, input int num);
        exp_q.push_back({err, 16'(num)});
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_aw_ready"}, int'(aw_issue_ready_o), 1);
        chk({tag, "_b_ready"}, int'(b_ready_o), 0);
        chk({tag, "_idle"}, int'(idle_o), 1);
        chk({tag, "_done_valid"}, int'(done_valid_o), 0);
        chk({tag, "_done_err"}, int'(done_error_o), 0);
        chk({tag, "_done_num"}, int'(done_num_bursts_o), 0);
    endtask

    always @(negedge clk_i) begin : monitor
        logic [16:0] e;
        if (rst_ni && done_valid_o && done_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got err=%0d num=%0d expected none",
                         done_error_o, done_num_bursts_o);
            end else begin
                e = exp_q.pop_front();
                chk("done_error", int'(done_error_o), int'(e[16]));
                chk("done_num", int'(done_num_bursts_o), int'(e[15:0]));
            end
        end
    end

    initial begin
        // Reset state, with a stray B that must not be accepted
        b_valid_i = 1'b1;
        @(negedge clk_i);
        reset_outputs("rst");
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        b_valid_i = 1'b0;
        step();

        // Three OKAY bursts form one transfer; check latency 1
        issue(1'b0);
        issue(1'b0);
        issue(1'b1);
        chk("t1_busy", int'(idle_o), 0);
        exp_done(1'b0, 3);
        send_b(2'b00);
        send_b(2'b01);
        b_valid_i = 1'b1;
        b_resp_i  = 2'b00;
        @(negedge clk_i);
        chk("t1_last_b_ready", int'(b_ready_o), 1);
        chk("t1_done_pre", int'(done_valid_o), 0);
        step();
        b_valid_i = 1'b0;
        chk("t1_done_lat1", int'(done_valid_o), 1);
        step();
        step();
        chk("t1_idle", int'(idle_o), 1);

        // Sticky error, then accumulator cleared for the next transfer
        issue(1'b0);
        issue(1'b1);
        exp_done(1'b1, 2);
        send_b(2'b10);
        send_b(2'b00);
        issue(1'b1);
        exp_done(1'b0, 1);
        send_b(2'b00);
        issue(1'b1);
        exp_done(1'b1, 1);
        send_b(2'b11);
        step();

        // Fill to 16 outstanding; full blocks a push even with a pop
        for (int i = 0; i < 16; i++) begin
            issue(i == 15);
        end
        chk("full_aw_ready", int'(aw_issue_ready_o), 0);
        exp_done(1'b0, 16);
        exp_done(1'b0, 1);
        aw_issue_valid_i = 1'b1;
        aw_issue_last_i  = 1'b1;
        b_valid_i        = 1'b1;
        b_resp_i         = 2'b00;
        @(negedge clk_i);
        chk("full_17th_ready", int'(aw_issue_ready_o), 0);
        chk("full_b_ready", int'(b_ready_o), 1);
        step();
        b_valid_i = 1'b0;
        chk("after_pop_aw_ready", int'(aw_issue_ready_o), 1);
        step();
        aw_issue_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_b(2'b00);
        end
        step();
        chk("full_drain_idle", int'(idle_o), 1);

        // Back-pressure on done, then back-to-back reload
        issue(1'b1);
        issue(1'b1);
        issue(1'b0);
        issue(1'b1);
        exp_done(1'b1, 1);
        exp_done(1'b0, 1);
        exp_done(1'b1, 2);
        done_ready_i = 1'b0;
        send_b(2'b10);
        b_valid_i = 1'b1;
        b_resp_i  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("bp_b_ready", int'(b_ready_o), 0);
            chk("bp_valid", int'(done_valid_o), 1);
            chk("bp_err_stable", int'(done_error_o), 1);
            chk("bp_num_stable", int'(done_num_bursts_o), 1);
        end
        step();
        done_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_release_b_ready", int'(b_ready_o), 1);
        step();
        b_valid_i = 1'b0;
        chk("b2b_no_bubble", int'(done_valid_o), 1);
        chk("b2b_err", int'(done_error_o), 0);
        send_b(2'b11);
        send_b(2'b00);
        step();
        step();
        chk("bp_idle", int'(idle_o), 1);

        // B with empty FIFO is stalled
        b_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("empty_b_ready", int'(b_ready_o), 0);
            chk("empty_no_done", int'(done_valid_o), 0);
        end
        step();
        b_valid_i = 1'b0;

        // Reset mid-transfer after 2 of 3 responses
        issue(1'b0);
        issue(1'b0);
        issue(1'b1);
        send_b(2'b10);
        send_b(2'b00);
        rst_ni = 1'b0;
        @(negedge clk_i);
        reset_outputs("mid_rst");
        step();
        rst_ni = 1'b1;
        b_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("post_rst_b_ready", int'(b_ready_o), 0);
            chk("post_rst_no_done", int'(done_valid_o), 0);
        end
        step();
        b_valid_i = 1'b0;
        issue(1'b1);
        exp_done(1'b0, 1);
        send_b(2'b00);
        step();
        step();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("final_idle", int'(idle_o), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
